// File: rtl/control_campos_edicion.sv
// control_campos_edicion: edit-mode controller for the time/date/timer BCD counters.
// Owns the field selector en_count and the one-cycle enUP/enDOWN step commands
// decoded by every field counter; turns debounced button levels into field
// navigation and step commands.
// Optional feature macro: AUTOREPEAT_EN (hold-to-auto-repeat on up/down).
// Without it, each up/down press gives exactly one step.
module control_campos_edicion #(
    parameter int unsigned NUM_FIELDS = 9,
    parameter int unsigned HOLD_CYC   = 50_000_000,
    parameter int unsigned REP_CYC    = 10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       edit_en,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [3:0] en_count,
    output logic       enUP,
    output logic       enDOWN,
    output logic       edit_active
);

    localparam logic [3:0] FIRST_FIELD = 4'd1;
    localparam logic [3:0] LAST_FIELD  = 4'(NUM_FIELDS);

    // Reject configurations the field encoding or the cadence cannot express
    if (NUM_FIELDS < 1 || NUM_FIELDS > 15 || HOLD_CYC < 2 || REP_CYC < 2) begin : g_bad_param
        $error("control_campos_edicion: NUM_FIELDS must be 1..15, HOLD_CYC and REP_CYC at least 2");
    end

`ifdef AUTOREPEAT_EN
    localparam int unsigned MAX_CYC = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
    localparam int unsigned CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RELEASE = 3'd1,
        WAIT    = 3'd2,
        DELAY   = 3'd3,
        REPEAT  = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RELEASE = 2'd1,
        WAIT    = 2'd2
    } state_t;
`endif

    state_t     state_q;
    state_t     state_d;
    logic [3:0] en_count_d;
    logic       up_d;
    logic       down_d;
    logic       edit_active_d;
    logic [2:0] btn_cnt;
    logic       any_btn;
    logic       multi_btn;

`ifdef AUTOREPEAT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             held_up_q;
    logic             held_up_d;
    logic             held_btn;
    logic             other_btn;
    logic [CNT_W-1:0] cnt_last;
`endif

    // Button population: none / exactly one / conflicting
    always_comb begin
        btn_cnt   = 3'(btn_left) + 3'(btn_right) + 3'(btn_up) + 3'(btn_down);
        any_btn   = (btn_cnt != 3'd0);
        multi_btn = (btn_cnt > 3'd1);
    end

    // Next state and next registered outputs
    always_comb begin
        state_d    = state_q;
        en_count_d = en_count;
        up_d       = 1'b0;
        down_d     = 1'b0;
`ifdef AUTOREPEAT_EN
        cnt_d     = cnt_q;
        held_up_d = held_up_q;
        held_btn  = held_up_q ? btn_up : btn_down;
        other_btn = btn_left | btn_right | (held_up_q ? btn_down : btn_up);
        cnt_last  = (state_q == DELAY) ? HOLD_LAST : REP_LAST;
`endif

        if (!edit_en) begin
            state_d    = IDLE;
            en_count_d = 4'd0;
`ifdef AUTOREPEAT_EN
            cnt_d = '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    en_count_d = FIRST_FIELD;
                    state_d    = RELEASE;
                end
                RELEASE: begin
                    if (!any_btn) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (multi_btn) begin
                        state_d = RELEASE;
                    end else if (btn_right) begin
                        en_count_d = (en_count == LAST_FIELD) ? FIRST_FIELD : en_count + 4'd1;
                        state_d    = RELEASE;
                    end else if (btn_left) begin
                        en_count_d = (en_count == FIRST_FIELD) ? LAST_FIELD : en_count - 4'd1;
                        state_d    = RELEASE;
                    end else if (btn_up || btn_down) begin
                        up_d   = btn_up;
                        down_d = btn_down;
`ifdef AUTOREPEAT_EN
                        held_up_d = btn_up;
                        cnt_d     = '0;
                        state_d   = DELAY;
`else
                        state_d = RELEASE;
`endif
                    end
                end
`ifdef AUTOREPEAT_EN
                DELAY, REPEAT: begin
                    if (other_btn) begin
                        cnt_d   = '0;
                        state_d = RELEASE;
                    end else if (!held_btn) begin
                        cnt_d   = '0;
                        state_d = WAIT;
                    end else if (cnt_q == cnt_last) begin
                        up_d    = held_up_q;
                        down_d  = !held_up_q;
                        cnt_d   = '0;
                        state_d = REPEAT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`endif
                default: begin
                    state_d    = IDLE;
                    en_count_d = 4'd0;
                end
            endcase
        end

        edit_active_d = (state_d != IDLE);
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            en_count    <= 4'd0;
            enUP        <= 1'b0;
            enDOWN      <= 1'b0;
            edit_active <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_count    <= en_count_d;
            enUP        <= up_d;
            enDOWN      <= down_d;
            edit_active <= edit_active_d;
        end
    end

`ifdef AUTOREPEAT_EN
    // Repeat counter and remembered direction of the held button
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q     <= '0;
            held_up_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            held_up_q <= held_up_d;
        end
    end
`endif

endmodule

// File: tb/tb_control_campos_edicion.sv
// Directed self-checking bench for control_campos_edicion (NUM_FIELDS=9,
// HOLD_CYC=8, REP_CYC=4). Expected pulse patterns follow AUTOREPEAT_EN.
module tb_control_campos_edicion;

    logic       clk;
    logic       reset;
    logic       edit_en;
    logic       btn_left;
    logic       btn_right;
    logic       btn_up;
    logic       btn_down;
    logic [3:0] en_count;
    logic       enUP;
    logic       enDOWN;
    logic       edit_active;

    int errors;
    int checks;
    int n_up;
    int n_dn;
    int n_both;
    int up_base;
    int dn_base;
    logic [31:0] up_mask;

`ifdef AUTOREPEAT_EN
    localparam logic [31:0] EXP_UP_MASK   = 32'h0111_1101;
    localparam int          EXP_UP_HOLD   = 6;
    localparam int          EXP_DN_ABORT  = 2;
`else
    localparam logic [31:0] EXP_UP_MASK   = 32'h0000_0001;
    localparam int          EXP_UP_HOLD   = 1;
    localparam int          EXP_DN_ABORT  = 1;
`endif

    control_campos_edicion #(
        .NUM_FIELDS (9),
        .HOLD_CYC   (8),
        .REP_CYC    (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .edit_en     (edit_en),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .en_count    (en_count),
        .enUP        (enUP),
        .enDOWN      (enDOWN),
        .edit_active (edit_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then sample 1 time unit later and tally pulses
    task automatic tick();
        @(posedge clk);
        #1;
        if (enUP === 1'b1) n_up++;
        if (enDOWN === 1'b1) n_dn++;
        if (enUP === 1'b1 && enDOWN === 1'b1) n_both++;
    endtask

    initial begin
        errors = 0; checks = 0; n_up = 0; n_dn = 0; n_both = 0;
        reset = 1'b0; edit_en = 1'b1;
        btn_left = 1'b0; btn_right = 1'b0; btn_up = 1'b1; btn_down = 1'b0;

        // Reset dominates edit_en and a held button
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_en_count", 32'(en_count), 32'd0);
            check("rst_enUP", 32'(enUP), 32'd0);
            check("rst_enDOWN", 32'(enDOWN), 32'd0);
            check("rst_edit_active", 32'(edit_active), 32'd0);
        end

        // Edit entry
        reset = 1'b1; btn_up = 1'b0;
        tick();
        check("entry_en_count", 32'(en_count), 32'd1);
        check("entry_edit_active", 32'(edit_active), 32'd1);
        tick();

        // Navigation with wrap
        btn_left = 1'b1; tick(); check("left_wrap", 32'(en_count), 32'd9);
        btn_left = 1'b0; tick();
        btn_right = 1'b1; tick(); check("right_wrap", 32'(en_count), 32'd1);
        btn_right = 1'b0; tick();
        for (int i = 0; i < 3; i++) begin
            btn_right = 1'b1; tick();
            btn_right = 1'b0; tick();
        end
        check("right_x3", 32'(en_count), 32'd4);
        btn_right = 1'b1;
        tick();
        check("right_hold_first", 32'(en_count), 32'd5);
        for (int i = 1; i < 20; i++) tick();
        check("right_hold_once", 32'(en_count), 32'd5);
        btn_right = 1'b0; tick();
        check("nav_no_pulses", 32'(n_up + n_dn), 32'd0);

        // Up held 25 cycles from WAIT
        up_base = n_up; dn_base = n_dn; up_mask = '0;
        btn_up = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (enUP === 1'b1) up_mask[i] = 1'b1;
        end
        btn_up = 1'b0; tick();
        check("up_hold_mask", up_mask, EXP_UP_MASK);
        check("up_hold_count", 32'(n_up - up_base), 32'(EXP_UP_HOLD));
        check("up_hold_no_down", 32'(n_dn - dn_base), 32'd0);
        check("up_hold_field", 32'(en_count), 32'd5);

        // Second press after release gives a fresh pulse
        up_base = n_up;
        btn_up = 1'b1; tick();
        check("up_repress_pulse", 32'(enUP), 32'd1);
        btn_up = 1'b0; tick();
        check("up_repress_count", 32'(n_up - up_base), 32'd1);

        // Conflicting up+down produce nothing
        up_base = n_up; dn_base = n_dn;
        btn_up = 1'b1; btn_down = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        btn_up = 1'b0; btn_down = 1'b0; tick();
        check("conflict_no_pulse", 32'(n_up - up_base + n_dn - dn_base), 32'd0);
        btn_down = 1'b1; tick();
        check("down_tap_pulse", 32'(enDOWN), 32'd1);
        btn_down = 1'b0; tick();
        check("down_tap_count", 32'(n_dn - dn_base), 32'd1);

        // Drop edit_en while down is held
        dn_base = n_dn;
        btn_down = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("down_hold_count", 32'(n_dn - dn_base), 32'(EXP_DN_ABORT));
        dn_base = n_dn;
        edit_en = 1'b0; tick();
        check("abort_en_count", 32'(en_count), 32'd0);
        check("abort_edit_active", 32'(edit_active), 32'd0);
        check("abort_enDOWN", 32'(enDOWN), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        edit_en = 1'b1; tick();
        check("reentry_en_count", 32'(en_count), 32'd1);
        check("reentry_edit_active", 32'(edit_active), 32'd1);
        for (int i = 0; i < 3; i++) tick();
        check("reentry_held_no_pulse", 32'(n_dn - dn_base), 32'd0);
        btn_down = 1'b0; tick();
        btn_down = 1'b1; tick();
        check("reentry_repress_pulse", 32'(enDOWN), 32'd1);
        btn_down = 1'b0; tick();
        check("reentry_repress_count", 32'(n_dn - dn_base), 32'd1);
        check("reentry_field_kept", 32'(en_count), 32'd1);

        check("never_both_pulses", 32'(n_both), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_campos_edicion.md
# control_campos_edicion

Edit-mode controller for the time/date/timer BCD counters. It owns the field selector `en_count` and the single-cycle `enUP`/`enDOWN` step commands that every field counter (seconds, minutes, hours, date, timer fields) decodes. It turns debounced push-button levels into field navigation and step commands, with hold-to-auto-repeat. It sits between the button debouncers and the bank of field counters.

## Interface
- `NUM_FIELDS`, 9: number of editable fields; field codes are 1..NUM_FIELDS, code 0 means no edit. Range 1..15.
- `HOLD_CYC`, 50_000_000: cycles from the first step pulse to the first auto-repeat pulse (0.5 s at 100 MHz). Minimum 2.
- `REP_CYC`, 10_000_000: cycles between auto-repeat pulses (10 Hz). Minimum 2.
- `clk` in 1: system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `edit_en` in 1: edit-mode switch level; 1 = editing.
- `btn_left` in 1: debounced level; select previous field.
- `btn_right` in 1: debounced level; select next field.
- `btn_up` in 1: debounced level; step the selected field up.
- `btn_down` in 1: debounced level; step the selected field down.
- `en_count` out 4: selected field code; 0 when not editing.
- `enUP` out 1: one-cycle increment command.
- `enDOWN` out 1: one-cycle decrement command.
- `edit_active` out 1: 1 in every state except IDLE.

## Operation
- All outputs are registered. Reset values: `en_count`=0, `enUP`=0, `enDOWN`=0, `edit_active`=0, state IDLE, repeat counter 0.
- States: IDLE, RELEASE, WAIT, DELAY, REPEAT.
- IDLE:
  - If `edit_en`=1: `en_count`←1 and go to RELEASE.
- RELEASE:
  - Wait until all four buttons are sampled low, then go to WAIT.
  - No commands are issued in this state.
  - Buttons held at edit entry or after an action therefore never trigger.
- WAIT, with exactly one button high:
  - `btn_right`: `en_count`←`en_count`+1; NUM_FIELDS wraps to 1. Go to RELEASE.
  - `btn_left`: `en_count`←`en_count`−1; 1 wraps to NUM_FIELDS. Go to RELEASE.
  - `btn_up` or `btn_down`: pulse `enUP` or `enDOWN` for one cycle, clear the counter, go to DELAY.
- WAIT, with two or more buttons high in the same cycle: no action, go to RELEASE.
- DELAY: the counter increments each cycle.
  - At count HOLD_CYC−1, the same button still solely held: issue a pulse, clear the counter, go to REPEAT.
- REPEAT: same behaviour as DELAY, with period REP_CYC.
- DELAY/REPEAT, held button released with no other button high: go to WAIT.
- DELAY/REPEAT, any other button high: abort with no pulse, go to RELEASE.
- `edit_en` sampled 0 in any state: go to IDLE at that edge. `en_count`←0, pulses forced 0, counter cleared. Re-entry always restarts at field 1.
- `enUP` and `enDOWN` are never high in the same cycle. `en_count` never changes in a cycle where a pulse is high.

## Timing
- Latency:
  - A button sampled high in WAIT at edge n: the resulting pulse or `en_count` change is visible after edge n and lasts one cycle for pulses.
  - Edit entry: `edit_en` sampled 1 at edge n gives `en_count`=1 and `edit_active`=1 after edge n.
- Auto-repeat cadence, with the first pulse at edge n:
  - Second pulse at edge n+HOLD_CYC.
  - Following pulses every REP_CYC edges.
  - Pulse count for a hold of H cycles: 1 if H ≤ HOLD_CYC, otherwise 1+⌊(H−1−HOLD_CYC)/REP_CYC⌋+1.
- Counter width is $clog2 of max(HOLD_CYC, REP_CYC). The counter never wraps; it is cleared on every pulse and on every state exit.
- Reset during any state takes priority over `edit_en` and the buttons. All outputs show their reset values after that edge.

## Configuration
- `AUTOREPEAT_EN` defined: DELAY/REPEAT behaviour as above.
- `AUTOREPEAT_EN` undefined:
  - DELAY and REPEAT and the repeat counter are not built.
  - An up/down press in WAIT issues exactly one pulse and goes to RELEASE, so each press gives one step.
  - HOLD_CYC and REP_CYC are ignored.

## Test plan
Parameters: NUM_FIELDS=9, HOLD_CYC=8, REP_CYC=4; `AUTOREPEAT_EN` defined unless noted.
- Reset: `reset`=0 for 3 cycles with `edit_en`=1 and `btn_up`=1 → `en_count`=0, `enUP`=`enDOWN`=0, `edit_active`=0 throughout.
- Navigation: `edit_en`=1 → `en_count`=1. Then:
  - `btn_left` tap → 9.
  - `btn_right` tap → 1.
  - 3 separate `btn_right` taps → 4.
  - `btn_right` held for 20 cycles → exactly one change.
- Auto-repeat: `btn_up` held 25 cycles from WAIT → `enUP` pulses at relative edges 0, 8, 12, 16, 20, 24 (6 pulses); `enDOWN` stays 0.
- Conflict: `btn_up` and `btn_down` rise in the same cycle and are held for 10 cycles → no pulses. After release, a `btn_down` tap → exactly one `enDOWN` pulse.
- Abort: during REPEAT from `btn_down`, drop `edit_en` → after the next edge `en_count`=0 and no further pulses. Re-enable with `btn_down` still held → `en_count`=1 and no pulse until the button is released and pressed again.
- `AUTOREPEAT_EN` undefined: `btn_up` held 25 cycles → exactly one `enUP` pulse. A second press → a second pulse.
